// File: rtl/seven_seg_scanner_pkg.sv
// seven_seg_scanner_pkg
//   Shared constants for the seven-segment display path.
//   Segment vectors are active-low, ordered a..g at bits [6]..[0].
package seven_seg_scanner_pkg;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_BLANK    = 7'h7F;
  // Nibble code the decoder renders as dark; used as the "no data" value.
  localparam logic [3:0] NIBBLE_BLANK = 4'hF;

  // Segment bit positions inside a 7-bit segment vector.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// seven_seg_scanner_decoder
//   BCD to seven-segment decoder (combinational, active-low outputs).
//   Ports:
//     bcd  in  4  digit code; 0-9 give glyphs, 10-15 give all segments dark
//     seg  out 7  segments a..g at [6]..[0], 0 = lit
//   The dark result for 10-15 is relied on upstream as the blank code.
module seven_seg_scanner_decoder
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'h01;
      4'd1: seg = 7'h4F;
      4'd2: seg = 7'h12;
      4'd3: seg = 7'h06;
      4'd4: seg = 7'h4C;
      4'd5: seg = 7'h24;
      4'd6: seg = 7'h20;
      4'd7: seg = 7'h0F;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h04;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for a NUM_DIGITS-digit common-anode display.
//   Ports:
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     value_in    in   packed BCD, nibble k = digit k (digit 0 rightmost)
//     dp_in       in   decimal point per digit, 1 = lit
//     blank_in    in   force digit dark, 1 = blank
//     load        in   capture value_in/dp_in/blank_in into shadow regs
//     seg_out     out  segments a..g at [6]..[0], active-low
//     dp_out      out  decimal point, active-low
//     an_out      out  anode enables, active-low, at most one low
//     frame_tick  out  one-cycle pulse when the scan wraps to digit 0
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 1000,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      LAST_PRE  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]      GUARD_END = PRE_W'(GUARD_CYC);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  logic [4*NUM_DIGITS-1:0] value_sh_reg;
  logic [NUM_DIGITS-1:0]   dp_sh_reg;
  logic [NUM_DIGITS-1:0]   blank_sh_reg;
  logic [PRE_W-1:0]        pre_reg, pre_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic                    frame_reg, frame_next;

  logic [3:0]            nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] nib_zero;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [NUM_DIGITS-1:0] eff_blank;
  logic [6:0]            dec_seg;

  // A digit is a leading zero when it and every more-significant nibble
  // are zero. Digit 0 is always shown so a zero value still reads "0".
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nibble[gi]   = value_sh_reg[gi*4 +: 4];
    assign nib_zero[gi] = (nibble[gi] == 4'd0);
    if (gi == 0) begin : g_lsd
      assign lz_blank[gi] = 1'b0;
    end else begin : g_upper
      assign lz_blank[gi] = (LZ_SUPPRESS != 0) && (&nib_zero[NUM_DIGITS-1:gi]);
    end
  end

  assign eff_blank = blank_sh_reg | lz_blank;

  seven_seg_scanner_decoder u_decoder (
    .bcd (nibble[idx_reg]),
    .seg (dec_seg)
  );

  always_comb begin
    pre_next   = pre_reg + PRE_W'(1);
    idx_next   = idx_reg;
    frame_next = 1'b0;
    if (pre_reg == LAST_PRE) begin
      pre_next   = '0;
      idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
      frame_next = (idx_reg == LAST_IDX);
    end

    // Pins follow the current slot one cycle later; the guard window at the
    // start of each slot keeps every anode off while segments settle.
    an_next  = '1;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if ((pre_reg >= GUARD_END) && !eff_blank[idx_reg]) begin
      an_next  = ~(AN_ONE << idx_reg);
      seg_next = dec_seg;
      dp_next  = ~dp_sh_reg[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_sh_reg <= {NUM_DIGITS{NIBBLE_BLANK}};
      dp_sh_reg    <= '0;
      blank_sh_reg <= '1;
      pre_reg      <= '0;
      idx_reg      <= '0;
      seg_reg      <= SEG_BLANK;
      dp_reg       <= 1'b1;
      an_reg       <= '1;
      frame_reg    <= 1'b0;
    end else begin
      if (load) begin
        value_sh_reg <= value_in;
        dp_sh_reg    <= dp_in;
        blank_sh_reg <= blank_in;
      end
      pre_reg   <= pre_next;
      idx_reg   <= idx_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      an_reg    <= an_next;
      frame_reg <= frame_next;
    end
  end

  assign seg_out    = seg_reg;
  assign dp_out     = dp_reg;
  assign an_out     = an_reg;
  assign frame_tick = frame_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Drives two scanner instances (leading-zero blanking off and on) with the
//   same stimulus and compares every cycle against a behavioural display
//   model derived from elapsed cycles since reset release.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1, ft0, ft1;
  logic [3:0] an0, an1;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYC(GUARD), .LZ_SUPPRESS(0)) dut_lz0 (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .seg_out(seg0), .dp_out(dp0), .an_out(an0), .frame_tick(ft0)
  );

  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYC(GUARD), .LZ_SUPPRESS(1)) dut_lz1 (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .seg_out(seg1), .dp_out(dp1), .an_out(an1), .frame_tick(ft1)
  );

  int total = 0;
  int bad   = 0;

  // Model state: m_* is the latched data, d_* is the data the pins show
  // (what was latched before the most recent edge); k counts edges since
  // reset release.
  logic [15:0] m_val, d_val;
  logic [3:0]  m_dp, d_dp, m_blank, d_blank;
  int          k;

  logic [12:0] e0, e1;

  // Glyph built from the names of the lit segments.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    string lit;
    logic [6:0] g;
    case (n)
      4'd0: lit = "abcdef";
      4'd1: lit = "bc";
      4'd2: lit = "abdeg";
      4'd3: lit = "abcdg";
      4'd4: lit = "bcfg";
      4'd5: lit = "acdfg";
      4'd6: lit = "acdefg";
      4'd7: lit = "abc";
      4'd8: lit = "abcdefg";
      4'd9: lit = "abcdfg";
      default: lit = "";
    endcase
    g = 7'h7F;
    for (int i = 0; i < lit.len(); i++) g[6 - (int'(lit[i]) - 97)] = 1'b0;
    return g;
  endfunction

  // Expected {an, seg, dp, frame_tick} for a display with/without
  // leading-zero blanking.
  function automatic logic [12:0] expect_out(input int lz);
    int p, d;
    logic ft, dark;
    logic [3:0] an;
    if (k == 0) return {4'hF, 7'h7F, 1'b1, 1'b0};
    p    = (k - 1) % DIV;
    d    = ((k - 1) / DIV) % N;
    ft   = (k % (DIV * N)) == 0;
    dark = (p < GUARD) || d_blank[d] || ((lz != 0) && (d > 0) && ((d_val >> (4 * d)) == 16'h0));
    if (dark) return {4'hF, 7'h7F, 1'b1, ft};
    an = 4'hF;
    an[d] = 1'b0;
    return {an, glyph(d_val[4*d +: 4]), ~d_dp[d], ft};
  endfunction

  task automatic model_reset();
    m_val = 16'hFFFF; m_dp = 4'h0; m_blank = 4'hF;
    d_val = m_val;    d_dp = m_dp; d_blank = m_blank;
    k = 0;
  endtask

  // One clock edge: advances the model, then returns at the falling edge
  // with e0/e1 holding the expected pins for both instances.
  task automatic step();
    d_val = m_val; d_dp = m_dp; d_blank = m_blank;
    if (load) begin
      m_val = value_in; m_dp = dp_in; m_blank = blank_in;
    end
    @(posedge clk);
    k++;
    @(negedge clk);
    e0 = expect_out(0);
    e1 = expect_out(1);
    load = 1'b0;
  endtask

  task automatic set_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value_in = v; dp_in = dp; blank_in = bl; load = 1'b1;
    $display("load value=%h dp=%b blank=%b at k=%0d", v, dp, bl, k);
  endtask

  task automatic test_reset();
    int pulses;
    model_reset();
    #23;
    total += 2;
    if ({an0, seg0, dp0, ft0} !== expect_out(0)) begin
      bad++; $display("FAIL reset_hold lz0 got=%h want=%h", {an0, seg0, dp0, ft0}, expect_out(0));
    end
    if ({an1, seg1, dp1, ft1} !== expect_out(1)) begin
      bad++; $display("FAIL reset_hold lz1 got=%h want=%h", {an1, seg1, dp1, ft1}, expect_out(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      pulses += int'(ft1);
      total += 2;
      if ({an0, seg0, dp0, ft0} !== e0) begin
        bad++; $display("FAIL reset_dark lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
      end
      if ({an1, seg1, dp1, ft1} !== e1) begin
        bad++; $display("FAIL reset_dark lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
      end
    end
    total++;
    if (pulses !== 2) begin
      bad++; $display("FAIL frame_tick_count got=%0d want=2", pulses);
    end
  endtask

  task automatic test_scan_order();
    set_load(16'h4321, 4'h0, 4'h0);
    for (int i = 0; i < 36; i++) begin
      step();
      total += 2;
      if ({an0, seg0, dp0, ft0} !== e0) begin
        bad++; $display("FAIL scan_order lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
      end
      if ({an1, seg1, dp1, ft1} !== e1) begin
        bad++; $display("FAIL scan_order lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] vals [2];
    vals[0] = 16'h0050;
    vals[1] = 16'h0000;
    for (int t = 0; t < 2; t++) begin
      set_load(vals[t], 4'h0, 4'h0);
      for (int i = 0; i < 34; i++) begin
        step();
        total += 2;
        if ({an0, seg0, dp0, ft0} !== e0) begin
          bad++; $display("FAIL lz_blank lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
        end
        if ({an1, seg1, dp1, ft1} !== e1) begin
          bad++; $display("FAIL lz_blank lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    set_load(16'h9999, 4'b0001, 4'b0100);
    for (int i = 0; i < 34; i++) begin
      step();
      total += 2;
      if ({an0, seg0, dp0, ft0} !== e0) begin
        bad++; $display("FAIL blank_dp lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
      end
      if ({an1, seg1, dp1, ft1} !== e1) begin
        bad++; $display("FAIL blank_dp lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
      end
    end
    set_load(16'h99A9, 4'b0001, 4'b0000);
    for (int i = 0; i < 34; i++) begin
      step();
      total += 2;
      if ({an0, seg0, dp0, ft0} !== e0) begin
        bad++; $display("FAIL code_a_dark lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
      end
      if ({an1, seg1, dp1, ft1} !== e1) begin
        bad++; $display("FAIL code_a_dark lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
      end
    end
  endtask

  task automatic test_load_at_advance();
    set_load(16'h1111, 4'h0, 4'h0);
    step();
    // Walk forward until the coming edge is a slot boundary, then load.
    for (int i = 0; i < 2 * DIV && ((k + 1) % DIV) != 0; i++) step();
    set_load(16'h8765, 4'b1010, 4'h0);
    for (int i = 0; i < 24; i++) begin
      step();
      total += 2;
      if ({an0, seg0, dp0, ft0} !== e0) begin
        bad++; $display("FAIL load_at_advance lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
      end
      if ({an1, seg1, dp1, ft1} !== e1) begin
        bad++; $display("FAIL load_at_advance lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    set_load(16'h2468, 4'hF, 4'h0);
    for (int i = 0; i < 9; i++) step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    total += 2;
    if ({an0, seg0, dp0, ft0} !== expect_out(0)) begin
      bad++; $display("FAIL reset_async lz0 got=%h want=%h", {an0, seg0, dp0, ft0}, expect_out(0));
    end
    if ({an1, seg1, dp1, ft1} !== expect_out(1)) begin
      bad++; $display("FAIL reset_async lz1 got=%h want=%h", {an1, seg1, dp1, ft1}, expect_out(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 44; i++) begin
      if (i == 20) set_load(16'h3057, 4'b0100, 4'h0);
      step();
      total += 2;
      if ({an0, seg0, dp0, ft0} !== e0) begin
        bad++; $display("FAIL reset_restart lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
      end
      if ({an1, seg1, dp1, ft1} !== e1) begin
        bad++; $display("FAIL reset_restart lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 4; j++)
          v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        set_load(v, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
      end
      step();
      total += 2;
      if ({an0, seg0, dp0, ft0} !== e0) begin
        bad++; $display("FAIL random lz0 k=%0d got=%h want=%h", k, {an0, seg0, dp0, ft0}, e0);
      end
      if ({an1, seg1, dp1, ft1} !== e1) begin
        bad++; $display("FAIL random lz1 k=%0d got=%h want=%h", k, {an1, seg1, dp1, ft1}, e1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_lz_blank();
    test_blank_dp();
    test_load_at_advance();
    test_reset_mid_slot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
